// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Holds the default operand width and the controller state encoding so
// the top level and the datapath step agree on both.
package div_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_in   : partial remainder before the step
//   quo_in   : partial quotient / remaining dividend bits before the step
//   divisor  : divisor for the trial subtraction
//   rem_out  : partial remainder after the step
//   quo_out  : partial quotient after the step (new bit in the LSB)
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH+1:0] trial;
   logic             borrow;
   logic             trial_unused;

   // The {rem,quo} pair is shifted left, so the dividend MSB moves into the
   // remainder. The trial difference is one bit wider than the shifted
   // remainder so its top bit is a clean borrow flag.
   always_comb begin
      rem_shift = {rem_in, quo_in[WIDTH-1]};
      trial     = {1'b0, rem_shift} - {2'b00, divisor};
      borrow    = trial[WIDTH+1];
      if (borrow) begin
         rem_out = rem_shift[WIDTH-1:0];
      end else begin
         rem_out = trial[WIDTH-1:0];
      end
      quo_out = {quo_in[WIDTH-2:0], ~borrow};
   end

   // When there is no borrow the difference is below the divisor, so its
   // bit WIDTH is always zero and carries no information.
   assign trial_unused = trial[WIDTH];

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   start       : request pulse, only honoured while idle
//   dividend    : unsigned dividend, captured with an accepted start
//   divisor     : unsigned divisor, captured with an accepted start
//   busy        : high while an operation is running or completing
//   done        : one-cycle pulse when results are valid
//   quotient    : result quotient, held until the next accepted start
//   remainder   : result remainder, held until the next accepted start
//   div_by_zero : set with done when the divisor was zero
module sequential_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_work;
   logic [WIDTH-1:0] quo_work;
   logic [WIDTH-1:0] dsr_work;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             last_step;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_work),
      .quo_in  (quo_work),
      .divisor (dsr_work),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   assign last_step = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_step) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Working registers iterate during RUN; the visible results are only
   // written on the edge that enters DONE so partial values never leak out.
   // A zero divisor skips the iteration and reports the conventional
   // all-ones quotient with the dividend as remainder.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count       <= '0;
         rem_work    <= '0;
         quo_work    <= '0;
         dsr_work    <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dsr_work    <= divisor;
                  rem_work    <= '0;
                  quo_work    <= dividend;
                  count       <= '0;
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               rem_work <= step_rem;
               quo_work <= step_quo;
               count    <= count + CW'(1);
               if (last_step) begin
                  quotient  <= step_quo;
                  remainder <= step_rem;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
